// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC word
// bits, trained by resolved conditional branches, plus a saturating misprediction count.
module branch_predictor #(
   parameter int IDX_BITS = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      PCF,
   output logic             predTakenF,
   input  logic [31:0]      PCE,
   input  logic [2:0]       branchE,
   input  logic [1:0]       PCSrcE,
   input  logic             predTakenE,
   output logic             mispredictE,
   output logic [CNT_W-1:0] mispredCount
);

   localparam int ENTRIES = 1 << IDX_BITS;

   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;
   localparam logic [1:0] CTR_STRONG_NT = 2'b00;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] upd_idx;
   logic                cond_e;
   logic                taken_e;
   logic [ENTRIES-1:0]  pred_vec;
   logic [CNT_W-1:0]    miss_cnt_q;
   logic [CNT_W-1:0]    miss_cnt_d;

   // PC bits outside the index field are deliberately discarded so aliasing PCs share a counter.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PCF[31:IDX_BITS+2], PCF[1:0], PCE[31:IDX_BITS+2], PCE[1:0]};

   assign fetch_idx = PCF[IDX_BITS+1:2];
   assign upd_idx   = PCE[IDX_BITS+1:2];

   always_comb begin
      cond_e = 1'b0;
      case (branchE)
         3'b001, 3'b010, 3'b011, 3'b100: cond_e = 1'b1;
         default:                        cond_e = 1'b0;
      endcase
   end

   assign taken_e     = (PCSrcE == 2'b01);
   assign mispredictE = cond_e & (taken_e != predTakenE);

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic [1:0] ctr_q;
         logic [1:0] ctr_d;
         logic       hit;

         assign hit = cond_e && (upd_idx == IDX_BITS'(gi));

         always_comb begin
            ctr_d = ctr_q;
            if (taken_e) begin
               if (ctr_q != CTR_STRONG_T) ctr_d = ctr_q + 2'd1;
            end else begin
               if (ctr_q != CTR_STRONG_NT) ctr_d = ctr_q - 2'd1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               ctr_q <= CTR_WEAK_NT;
            end else if (hit) begin
               ctr_q <= ctr_d;
            end
         end

         assign pred_vec[gi] = ctr_q[1];
      end
   endgenerate

   // Read reflects only registered state, so a same-cycle update is not bypassed.
   assign predTakenF = pred_vec[fetch_idx];

   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (mispredictE && (miss_cnt_q != {CNT_W{1'b1}})) begin
         miss_cnt_d = miss_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         miss_cnt_q <= '0;
      end else begin
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign mispredCount = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, corner sequences,
// and randomized traffic against an integer-counter reference model.
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic [31:0] PCE;
   logic [2:0]  branchE;
   logic [1:0]  PCSrcE;
   logic        predTakenE;
   logic        predTakenF;
   logic        mispredictE;
   logic [15:0] mispredCount;
   logic        predTakenF4;
   logic        mispredictE4;
   logic [3:0]  mispredCount4;

   int checks = 0;
   int errors = 0;

   // Reference model: counter strength 0..3 per entry, miss total kept unbounded.
   int m_ctr[16];
   int m_miss;

   branch_predictor #(.IDX_BITS(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .PCF(PCF), .predTakenF(predTakenF),
      .PCE(PCE), .branchE(branchE), .PCSrcE(PCSrcE), .predTakenE(predTakenE),
      .mispredictE(mispredictE), .mispredCount(mispredCount)
   );

   branch_predictor #(.IDX_BITS(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .PCF(PCF), .predTakenF(predTakenF4),
      .PCE(PCE), .branchE(branchE), .PCSrcE(PCSrcE), .predTakenE(predTakenE),
      .mispredictE(mispredictE4), .mispredCount(mispredCount4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] pcf;
      logic [31:0] pce;
      logic [2:0]  br;
      logic [1:0]  src;
      logic        pte;
      logic        exp_pred;
      logic        exp_mis;
      int          exp_cnt;
   } vec_t;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) & 32'hF);
   endfunction

   function automatic bit m_cond(input logic [2:0] b);
      return (b >= 3'd1) && (b <= 3'd4);
   endfunction

   function automatic logic m_pred(input logic [31:0] pc);
      return (m_ctr[idx_of(pc)] >= 2) ? 1'b1 : 1'b0;
   endfunction

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_miss = 0;
   endtask

   // One clock transaction: drive, check combinational outputs, clock, check counts.
   task automatic apply(input logic [31:0] pcf, input logic [31:0] pce, input logic [2:0] br,
                        input logic [1:0] src, input logic pte, input string tag,
                        output logic pred_seen, output logic mis_seen);
      logic exp_pred;
      logic exp_mis;
      bit   taken;
      @(negedge clk);
      PCF = pcf; PCE = pce; branchE = br; PCSrcE = src; predTakenE = pte;
      #1;
      taken    = (src == 2'b01);
      exp_pred = m_pred(pcf);
      exp_mis  = (m_cond(br) && (taken != pte)) ? 1'b1 : 1'b0;
      pred_seen = predTakenF;
      mis_seen  = mispredictE;
      check({tag, ".predTakenF"}, predTakenF, exp_pred);
      check({tag, ".mispredictE"}, mispredictE, exp_mis);
      check({tag, ".predTakenF4"}, predTakenF4, exp_pred);
      @(posedge clk);
      if (m_cond(br)) begin
         if (taken) m_ctr[idx_of(pce)] = (m_ctr[idx_of(pce)] == 3) ? 3 : m_ctr[idx_of(pce)] + 1;
         else       m_ctr[idx_of(pce)] = (m_ctr[idx_of(pce)] == 0) ? 0 : m_ctr[idx_of(pce)] - 1;
      end
      if (exp_mis) m_miss++;
      #1;
      check({tag, ".mispredCount"}, mispredCount, (m_miss > 65535) ? 65535 : m_miss);
      check({tag, ".mispredCount4"}, mispredCount4, sat15(m_miss));
      $display("txn %s pcf=%08h pce=%08h br=%0d src=%0d pte=%0d -> pred=%0d mis=%0d cnt=%0d cnt4=%0d",
               tag, pcf, pce, br, src, pte, pred_seen, mis_seen, mispredCount, mispredCount4);
   endtask

   // Reset edge with a conflicting taken update driven at the same time.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1; PCE = 32'h10; branchE = 3'b001; PCSrcE = 2'b01; predTakenE = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
      branchE = 3'b000;
      check({tag, ".rst_cnt"}, mispredCount, 0);
      check({tag, ".rst_cnt4"}, mispredCount4, 0);
      $display("txn %s reset cnt=%0d cnt4=%0d", tag, mispredCount, mispredCount4);
   endtask

   vec_t vecs[14];

   initial begin
      logic ps, ms;
      logic [31:0] rpcf, rpce;
      logic [2:0]  rbr;
      logic [1:0]  rsrc;
      logic        rpte;

      rst = 1'b0; PCF = '0; PCE = '0; branchE = '0; PCSrcE = '0; predTakenE = 1'b0;
      model_reset();

      //           pcf       pce       br    src    pte   pred  mis  cnt
      vecs[0]  = '{32'h10, 32'h10, 3'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1};
      vecs[1]  = '{32'h10, 32'h10, 3'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1};
      vecs[2]  = '{32'h10, 32'h10, 3'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1};
      vecs[3]  = '{32'h10, 32'h10, 3'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1};
      vecs[4]  = '{32'h10, 32'h10, 3'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1};
      vecs[5]  = '{32'h10, 32'h10, 3'd1, 2'd0, 1'b1, 1'b1, 1'b1, 2};
      vecs[6]  = '{32'h10, 32'h20, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 2};
      vecs[7]  = '{32'h20, 32'h00, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2};
      vecs[8]  = '{32'h10, 32'h00, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2};
      vecs[9]  = '{32'h44, 32'h44, 3'd2, 2'd1, 1'b0, 1'b0, 1'b1, 3};
      vecs[10] = '{32'h44, 32'h00, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3};
      vecs[11] = '{32'h04, 32'h00, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3};
      vecs[12] = '{32'h44, 32'h44, 3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 3};
      vecs[13] = '{32'hFFFF_FF44, 32'h00, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3};

      do_reset("init");

      // Post-reset sweep: every entry predicts not-taken.
      for (int p = 0; p <= 32'h3C; p += 4) begin
         apply(32'(p), 32'h0, 3'd0, 2'd0, 1'b0, "sweep", ps, ms);
         check("sweep.pred0", ps, 0);
      end

      for (int i = 0; i < 14; i++) begin
         apply(vecs[i].pcf, vecs[i].pce, vecs[i].br, vecs[i].src, vecs[i].pte, "vec", ps, ms);
         check($sformatf("vec%0d.pred", i), ps, vecs[i].exp_pred);
         check($sformatf("vec%0d.mis", i), ms, vecs[i].exp_mis);
         check($sformatf("vec%0d.cnt", i), mispredCount, vecs[i].exp_cnt);
      end

      // Saturation of the narrow counter, then reset mid-sequence.
      do_reset("sat");
      for (int i = 0; i < 20; i++) begin
         apply(32'h80, 32'h80 + 32'(i % 3) * 4, 3'd3, 2'd1, 1'b0, "sat", ps, ms);
         check("sat.cnt4", mispredCount4, (i + 1 > 15) ? 15 : i + 1);
      end
      check("sat.cnt4_hold", mispredCount4, 15);
      check("sat.cnt16", mispredCount, 20);
      do_reset("sat_rst");
      for (int p = 0; p <= 32'h3C; p += 4) begin
         apply(32'(p), 32'h0, 3'd0, 2'd0, 1'b0, "sat_sweep", ps, ms);
         check("sat_sweep.pred0", ps, 0);
      end
      for (int i = 0; i < 3; i++) begin
         apply(32'h0, 32'h84, 3'd4, 2'd0, 1'b1, "sat_resume", ps, ms);
      end
      check("sat_resume.cnt4", mispredCount4, 3);

      // Randomized traffic against the reference model.
      do_reset("rand");
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset("rand_rst");
         end
         rpcf = $urandom();
         rpce = {$urandom_range(0, 255), 8'h0, 8'h0, 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         rbr  = 3'($urandom_range(0, 7));
         rsrc = 2'($urandom_range(0, 2));
         rpte = ($urandom_range(0, 1) == 0) ? m_pred(rpce) : 1'($urandom_range(0, 1));
         apply(rpcf, rpce, rbr, rsrc, rpte, "rand", ps, ms);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
